// File: rtl/mac_tx_mode.sv
// Frame-level TX arbiter: merges ARP and IP AXI-Stream sources into one registered frame stream,
// alternating grants between the sources and truncating frames that run past MAX_BEATS.
module mac_tx_mode #(
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 8
) (
    input  logic        tx_axis_aclk,
    input  logic        tx_axis_areset,
    input  logic [63:0] ip_tx_axis_tdata,
    input  logic [7:0]  ip_tx_axis_tkeep,
    input  logic        ip_tx_axis_tvalid,
    input  logic        ip_tx_axis_tlast,
    output logic        ip_tx_axis_tready,
    input  logic [47:0] ip_tx_dst_mac_addr,
    input  logic [63:0] arp_tx_axis_tdata,
    input  logic [7:0]  arp_tx_axis_tkeep,
    input  logic        arp_tx_axis_tvalid,
    input  logic        arp_tx_axis_tlast,
    output logic        arp_tx_axis_tready,
    input  logic [47:0] arp_tx_dst_mac_addr,
    output logic [63:0] frame_tx_axis_tdata,
    output logic [7:0]  frame_tx_axis_tkeep,
    output logic        frame_tx_axis_tvalid,
    output logic        frame_tx_axis_tlast,
    output logic        frame_tx_axis_tuser,
    input  logic        frame_tx_axis_tready,
    output logic [47:0] frame_mode_dst_mac_addr,
    output logic [15:0] frame_mode_type
);

    // state     | meaning
    // IDLE      | no source granted, choose next frame
    // SEND_ARP  | forwarding ARP frame to output register
    // SEND_IP   | forwarding IP frame to output register
    // DRAIN_ARP | over-length ARP frame: swallow beats until its tlast
    // DRAIN_IP  | over-length IP frame: swallow beats until its tlast
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_ARP  = 3'd1,
        SEND_IP   = 3'd2,
        DRAIN_ARP = 3'd3,
        DRAIN_IP  = 3'd4
    } state_t;

    localparam logic [15:0] TYPE_IP  = 16'h0800;
    localparam logic [15:0] TYPE_ARP = 16'h0806;

    state_t             state_q, state_d;
    logic               last_arp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [47:0]        mac_q;
    logic [15:0]        type_q;
    logic [63:0]        data_q;
    logic [7:0]         keep_q;
    logic               valid_q, last_q, user_q;

    logic               src_is_arp, src_valid, src_last, src_ready;
    logic [63:0]        src_data;
    logic [7:0]         src_keep;
    logic               out_free, in_send, send_acc, at_limit, force_abort;
    logic               grant_arp, grant_ip;

    assign src_is_arp  = (state_q == SEND_ARP) || (state_q == DRAIN_ARP);
    assign src_valid   = src_is_arp ? arp_tx_axis_tvalid : ip_tx_axis_tvalid;
    assign src_last    = src_is_arp ? arp_tx_axis_tlast  : ip_tx_axis_tlast;
    assign src_data    = src_is_arp ? arp_tx_axis_tdata  : ip_tx_axis_tdata;
    assign src_keep    = src_is_arp ? arp_tx_axis_tkeep  : ip_tx_axis_tkeep;
    assign src_ready   = src_is_arp ? arp_tx_axis_tready : ip_tx_axis_tready;

    assign out_free    = ~valid_q | frame_tx_axis_tready;
    assign in_send     = (state_q == SEND_ARP) || (state_q == SEND_IP);
    assign send_acc    = in_send & src_valid & src_ready;
    assign at_limit    = (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign force_abort = send_acc & ~src_last & at_limit;

    // ARP wins unless it had the previous grant and IP is also waiting.
    assign grant_arp = (state_q == IDLE) & arp_tx_axis_tvalid & (~last_arp_q | ~ip_tx_axis_tvalid);
    assign grant_ip  = (state_q == IDLE) & ~grant_arp & ip_tx_axis_tvalid;

    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_arp)     state_d = SEND_ARP;
                else if (grant_ip) state_d = SEND_IP;
            end
            SEND_ARP, SEND_IP: begin
                if (send_acc && src_last) state_d = IDLE;
                else if (force_abort)     state_d = (state_q == SEND_ARP) ? DRAIN_ARP : DRAIN_IP;
            end
            DRAIN_ARP, DRAIN_IP: begin
                if (src_valid && src_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ip_tx_axis_tready  = 1'b0;
        arp_tx_axis_tready = 1'b0;
        case (state_q)
            SEND_ARP:  arp_tx_axis_tready = out_free;
            SEND_IP:   ip_tx_axis_tready  = out_free;
            DRAIN_ARP: arp_tx_axis_tready = 1'b1;
            DRAIN_IP:  ip_tx_axis_tready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            last_arp_q <= 1'b0;
            cnt_q      <= '0;
            mac_q      <= '0;
            type_q     <= '0;
        end else if (grant_arp) begin
            last_arp_q <= 1'b1;
            cnt_q      <= '0;
            mac_q      <= arp_tx_dst_mac_addr;
            type_q     <= TYPE_ARP;
        end else if (grant_ip) begin
            last_arp_q <= 1'b0;
            cnt_q      <= '0;
            mac_q      <= ip_tx_dst_mac_addr;
            type_q     <= TYPE_IP;
        end else if (send_acc) begin
            cnt_q      <= cnt_q + CNT_W'(1);
        end
    end

    // Single output stage: loads only when empty or draining, so held beats never change.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (send_acc) begin
            valid_q <= 1'b1;
            data_q  <= src_data;
            keep_q  <= src_keep;
            last_q  <= src_last | force_abort;
            user_q  <= force_abort;
        end else if (frame_tx_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    assign frame_tx_axis_tdata     = data_q;
    assign frame_tx_axis_tkeep     = keep_q;
    assign frame_tx_axis_tvalid    = valid_q;
    assign frame_tx_axis_tlast     = last_q;
    assign frame_tx_axis_tuser     = user_q;
    assign frame_mode_dst_mac_addr = mac_q;
    assign frame_mode_type         = type_q;

endmodule

// File: tb/tb_mac_tx_mode.sv
// Bench for mac_tx_mode: frame-level expected-beat queue (with truncation rule) checked every
// transfer cycle, plus hold-stability, latency, reset and literal checks.
module tb_mac_tx_mode;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ip_data, arp_data, f_data;
    logic [7:0]  ip_keep, arp_keep, f_keep;
    logic        ip_valid, ip_last, ip_ready;
    logic        arp_valid, arp_last, arp_ready;
    logic [47:0] ip_mac, arp_mac, f_mac;
    logic        f_valid, f_last, f_user, f_ready;
    logic [15:0] f_type;

    always #5 clk = ~clk;

    mac_tx_mode #(.MAX_BEATS(MAXB), .CNT_W(8)) dut (
        .tx_axis_aclk            (clk),
        .tx_axis_areset          (rst),
        .ip_tx_axis_tdata        (ip_data),
        .ip_tx_axis_tkeep        (ip_keep),
        .ip_tx_axis_tvalid       (ip_valid),
        .ip_tx_axis_tlast        (ip_last),
        .ip_tx_axis_tready       (ip_ready),
        .ip_tx_dst_mac_addr      (ip_mac),
        .arp_tx_axis_tdata       (arp_data),
        .arp_tx_axis_tkeep       (arp_keep),
        .arp_tx_axis_tvalid      (arp_valid),
        .arp_tx_axis_tlast       (arp_last),
        .arp_tx_axis_tready      (arp_ready),
        .arp_tx_dst_mac_addr     (arp_mac),
        .frame_tx_axis_tdata     (f_data),
        .frame_tx_axis_tkeep     (f_keep),
        .frame_tx_axis_tvalid    (f_valid),
        .frame_tx_axis_tlast     (f_last),
        .frame_tx_axis_tuser     (f_user),
        .frame_tx_axis_tready    (f_ready),
        .frame_mode_dst_mac_addr (f_mac),
        .frame_mode_type         (f_type)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
        logic [47:0] mac;
        logic [15:0] ty;
    } beat_t;

    beat_t exp_q[$];
    int    acc_cyc_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    chk_lat = 0;
    bit    mon_en = 0;
    int    rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Frame model: beats base+i, last beat keep 0F; frames past MAXB cut at MAXB with tuser.
    function automatic void push_frame(bit arp, int n, logic [63:0] base, logic [47:0] mac);
        for (int i = 0; i < n; i++) begin
            if (i < MAXB) begin
                beat_t b;
                b.d   = base + 64'(i);
                b.k   = (i == n - 1) ? 8'h0F : 8'hFF;
                b.l   = (i == n - 1) || (i == MAXB - 1);
                b.u   = (i == MAXB - 1) && (i != n - 1);
                b.mac = mac;
                b.ty  = arp ? 16'h0806 : 16'h0800;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic drive(input bit arp, input int n, input logic [63:0] base, input logic [47:0] mac);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (arp) begin
                arp_mac = mac; arp_data = base + 64'(i);
                arp_keep = (i == n - 1) ? 8'h0F : 8'hFF;
                arp_last = (i == n - 1); arp_valid = 1'b1;
            end else begin
                ip_mac = mac; ip_data = base + 64'(i);
                ip_keep = (i == n - 1) ? 8'h0F : 8'hFF;
                ip_last = (i == n - 1); ip_valid = 1'b1;
            end
            forever begin
                @(negedge clk);
                if (arp ? arp_ready : ip_ready) break;
                t++;
                if (t > 200) begin
                    n_chk++; n_fail++;
                    $display("FAIL src_timeout: arp=%0d beat %0d never accepted", arp, i);
                    if (arp) arp_valid = 1'b0; else ip_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (chk_lat && !arp) acc_cyc_q.push_back(cyc);
        end
        if (arp) begin arp_valid = 1'b0; arp_last = 1'b0; end
        else     begin ip_valid = 1'b0;  ip_last = 1'b0;  end
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(nm, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) f_ready = 1'b1;
            else               f_ready = ~f_ready;
        end
    end

    initial begin
        beat_t cur, prev, e;
        logic  prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {f_data, f_keep, f_last, f_user, f_mac, f_type};
            if (mon_en) begin
                if (prev_stall) begin
                    n_chk++;
                    if (!f_valid || cur !== prev) begin
                        n_fail++;
                        $display("FAIL hold: got v=%0d %h held %h", f_valid, cur, prev);
                    end
                end
                if (f_valid && f_ready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_fail++;
                            $display("FAIL beat: got %h expected %h", cur, e);
                        end
                        if (chk_lat && acc_cyc_q.size() != 0) begin
                            int a;
                            a = acc_cyc_q.pop_front();
                            check("latency", 64'(cyc), 64'(a));
                        end
                    end
                end
                prev_stall = f_valid & ~f_ready;
                prev = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; f_ready = 1'b1;
        ip_data = '0; ip_keep = '0; ip_valid = 1'b1; ip_last = 1'b0; ip_mac = '0;
        arp_data = '0; arp_keep = '0; arp_valid = 1'b1; arp_last = 1'b0; arp_mac = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(f_valid), 64'd0);
        check("rst_tdata", f_data, 64'd0);
        check("rst_ip_trdy", 64'(ip_ready), 64'd0);
        check("rst_arp_trdy", 64'(arp_ready), 64'd0);
        check("rst_type", 64'(f_type), 64'd0);
        check("rst_mac", 64'(f_mac), 64'd0);
        ip_valid = 1'b0; arp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: single IP frame, latency and mode literals
        push_frame(0, 3, 64'h1000, 48'h0A0B0C0D0E0F);
        check("model_t1_last_keep", 64'(exp_q[2].k), 64'h0F);
        chk_lat = 1'b1;
        drive(0, 3, 64'h1000, 48'h0A0B0C0D0E0F);
        wait_drain("t1_drain");
        chk_lat = 1'b0;
        check("t1_type", 64'(f_type), 64'h0800);
        check("t1_mac", 64'(f_mac), 64'h0A0B0C0D0E0F);

        // 2: simultaneous ARP and IP after an IP grant -> ARP first
        push_frame(1, 2, 64'h2000, 48'h111111111111);
        push_frame(0, 3, 64'h3000, 48'h222222222222);
        fork
            drive(1, 2, 64'h2000, 48'h111111111111);
            drive(0, 3, 64'h3000, 48'h222222222222);
        join
        wait_drain("t2_drain");
        check("t2_type_after", 64'(f_type), 64'h0800);

        // 5: two queued ARP frames against one IP -> ARP, IP, ARP
        push_frame(1, 2, 64'h4000, 48'h333333333333);
        push_frame(0, 2, 64'h5000, 48'h444444444444);
        push_frame(1, 3, 64'h6000, 48'h555555555555);
        fork
            begin
                drive(1, 2, 64'h4000, 48'h333333333333);
                drive(1, 3, 64'h6000, 48'h555555555555);
            end
            drive(0, 2, 64'h5000, 48'h444444444444);
        join
        wait_drain("t5_drain");
        check("t5_type_after", 64'(f_type), 64'h0806);

        // 3: exactly MAXB beats under 1,0,1,0 backpressure -> no truncation
        rdy_mode = 1;
        push_frame(0, 8, 64'h7000, 48'h666666666666);
        check("model_t3_no_user", 64'(exp_q[7].u), 64'd0);
        drive(0, 8, 64'h7000, 48'h666666666666);
        wait_drain("t3_drain");
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // 4: over-length IP frame truncated, then a normal ARP frame
        push_frame(0, 10, 64'h8000, 48'h777777777777);
        check("model_t4_len", 64'(exp_q.size()), 64'd8);
        check("model_t4_user", 64'(exp_q[7].u), 64'd1);
        push_frame(1, 2, 64'h9000, 48'h888888888888);
        drive(0, 10, 64'h8000, 48'h777777777777);
        drive(1, 2, 64'h9000, 48'h888888888888);
        wait_drain("t4_drain");

        // 6: reset in the middle of an IP frame
        mon_en = 1'b0;
        ip_mac = 48'h999999999999; ip_data = 64'hA000; ip_keep = 8'hFF;
        ip_last = 1'b0; ip_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_pre_tvalid", 64'(f_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_tvalid", 64'(f_valid), 64'd0);
        check("t6_tdata", f_data, 64'd0);
        check("t6_ip_trdy", 64'(ip_ready), 64'd0);
        check("t6_type", 64'(f_type), 64'd0);
        ip_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        push_frame(1, 3, 64'hB000, 48'hAAAAAAAAAAAA);
        drive(1, 3, 64'hB000, 48'hAAAAAAAAAAAA);
        wait_drain("t6_drain");
        check("t6_type_after", 64'(f_type), 64'h0806);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
